// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: opcodes, FSM states, flag bit
// positions and register-file addresses.
package alu_exec_pkg;

    // Opcodes; 0xC..0xF (and 0xB when the multiplier is not built) are NOPs
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    // Bit positions inside flags = {N,V,C,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    localparam logic [2:0] REG_A  = 3'd0;
    localparam logic [2:0] REG_X  = 3'd1;
    localparam logic [2:0] REG_Y  = 3'd2;
    localparam logic [2:0] REG_Z  = 3'd3;
    localparam logic [2:0] REG_SP = 4'd4;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// shift_add_mul8: 8x8 -> 16 bit sequential multiplier, one shift-add step per
// cycle for 8 cycles. A start pulse while idle loads the operands; done is
// high during the last step, with product already holding the final value.
module shift_add_mul8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        done,
    output logic [15:0] product
);
    logic        active;
    logic [3:0]  cnt;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;

    // Accumulator after the current step; on the last step this is the product
    always_comb begin
        product = acc + (mplier[0] ? mcand : 16'h0000);
        done    = active && (cnt == 4'd7);
    end

    // Operand load on start, then shift multiplicand left / multiplier right
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= 4'd0;
            acc    <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == 4'd7) begin
                active <= 1'b0;
                cnt    <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else if (start) begin
            active <= 1'b1;
            cnt    <= 4'd0;
            acc    <= 16'h0000;
            mcand  <= {8'h00, a};
            mplier <= b;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage between register-file reads and write-back.
// Single-cycle ops write back one cycle after acceptance. Build with
// ALU_EXEC_MUL_EN defined to enable the 8-cycle multiply on opcode 0xB;
// without it 0xB is a NOP and busy is tied low.
module alu_exec_unit #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic [3:0]        flags,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    import alu_exec_pkg::*;

    localparam int MSB = DATA_W - 1;
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    // Handshake: an op transfers on a rising edge where issue_valid and
    // issue_ready are both high; operands are only sampled at that edge and
    // upstream must hold the op steady while issue_ready is low.
    state_t            state;
    logic              accept;
    logic              dest_ok;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_wr;
    logic              alu_upd;
    logic [3:0]        alu_flags;

    assign issue_ready = (state != S_MUL);
    assign accept      = issue_valid && issue_ready;
    assign dest_ok     = ({1'b0, dest_addr} < REG_LIMIT);
    assign dbg_state   = state;

`ifdef ALU_EXEC_MUL_EN
    logic              mul_done;
    logic [15:0]       mul_product;
    logic [ADDR_W-1:0] mul_dest;
    logic              mul_dest_ok;

    assign busy        = (state == S_MUL);
    assign mul_dest_ok = ({1'b0, mul_dest} < REG_LIMIT);

    shift_add_mul8 u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (opcode == OP_MUL)),
        .a       (src_a),
        .b       (src_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign busy = 1'b0;
`endif

    // Single-cycle datapath: result, flags and write/flag-update decode.
    // Logic ops and MOV clear C; only the arithmetic ops can set V.
    always_comb begin
        opnd_b    = (opcode == OP_INC || opcode == OP_DEC)
                    ? {{(DATA_W-1){1'b0}}, 1'b1} : src_b;
        sum_ext   = {1'b0, src_a} + {1'b0, opnd_b};
        diff_ext  = {1'b0, src_a} - {1'b0, opnd_b};
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_wr    = 1'b1;
        alu_upd   = 1'b1;
        case (opcode)
            OP_ADD, OP_INC: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (src_a[MSB] == opnd_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = diff_ext[DATA_W];
                alu_v   = (src_a[MSB] != opnd_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
                alu_wr  = (opcode != OP_CMP);
            end
            OP_AND: alu_res = src_a & src_b;
            OP_OR:  alu_res = src_a | src_b;
            OP_XOR: alu_res = src_a ^ src_b;
            OP_SHL: begin
                alu_res = {src_a[MSB-1:0], 1'b0};
                alu_c   = src_a[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, src_a[MSB:1]};
                alu_c   = src_a[0];
            end
            OP_MOV: alu_res = src_a;
            default: begin
                alu_wr  = 1'b0;
                alu_upd = 1'b0;
            end
        endcase
        alu_flags        = 4'b0000;
        alu_flags[FLG_N] = alu_res[MSB];
        alu_flags[FLG_V] = alu_v;
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_Z] = (alu_res == '0);
    end

    // Control FSM with registered write-back port and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            flags        <= 4'b0000;
`ifdef ALU_EXEC_MUL_EN
            mul_dest     <= '0;
`endif
        end else begin
            write_enable <= 1'b0;
            case (state)
                S_IDLE, S_WB: begin
                    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                        if (opcode == OP_MUL) begin
                            state    <= S_MUL;
                            mul_dest <= dest_addr;
                        end else
`endif
                        begin
                            state <= S_WB;
                            if (alu_wr && dest_ok) begin
                                write_enable <= 1'b1;
                                write_addr   <= dest_addr;
                                write_data   <= alu_res;
                            end
                            if (alu_upd) begin
                                flags <= alu_flags;
                            end
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    if (mul_done) begin
                        state <= S_WB;
                        if (mul_dest_ok) begin
                            write_enable <= 1'b1;
                            write_addr   <= mul_dest;
                            write_data   <= mul_product[MSB:0];
                        end
                        flags        <= 4'b0000;
                        flags[FLG_N] <= mul_product[MSB];
                        flags[FLG_C] <= (mul_product[15:8] != 8'h00);
                        flags[FLG_Z] <= (mul_product[MSB:0] == '0);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed literal cases plus randomized ops
// checked every cycle against a cycle-count behavioural model.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] opcode;
    logic [2:0] dest_addr;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic       write_enable;
    logic [3:0] flags;
    logic       busy;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .opcode       (opcode),
        .dest_addr    (dest_addr),
        .src_a        (src_a),
        .src_b        (src_b),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .flags        (flags),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         started = 0;
    bit         m_we;
    int         m_addr;
    int         m_data;
    logic [3:0] m_flags;
    int         m_left;
    int         p_data;
    int         p_dest;
    bit         p_c;

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Result and {N,V,C,Z} of one single-cycle op, from the arithmetic rules
    function automatic void model_op(input int op, input int a, input int b,
                                     output bit wr, output bit upd,
                                     output int r, output logic [3:0] fl);
        bit c;
        bit v;
        wr = 1; upd = 1; c = 0; v = 0; r = 0;
        case (op)
            0:  begin r = (a + b) % 256; c = (a + b) > 255; v = ovf(sgn(a) + sgn(b)); end
            1:  begin r = (a - b + 256) % 256; c = a < b; v = ovf(sgn(a) - sgn(b)); end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  begin r = (a * 2) % 256; c = a >= 128; end
            6:  begin r = a / 2; c = (a % 2) == 1; end
            7:  r = a;
            8:  begin r = (a + 1) % 256; c = a == 255; v = ovf(sgn(a) + 1); end
            9:  begin r = (a + 255) % 256; c = a == 0; v = ovf(sgn(a) - 1); end
            10: begin r = (a - b + 256) % 256; c = a < b; v = ovf(sgn(a) - sgn(b)); wr = 0; end
            default: begin wr = 0; upd = 0; end
        endcase
        fl = {r >= 128, v, c, r == 0};
    endfunction

    always @(posedge clk) begin
        bit         wr;
        bit         upd;
        int         r;
        logic [3:0] fl;
        started = 1;
        if (reset) begin
            m_we = 0; m_addr = 0; m_data = 0; m_flags = 4'h0; m_left = 0;
        end else begin
            m_we = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_we    = p_dest < 5;
                    if (m_we) begin
                        m_addr = p_dest;
                        m_data = p_data;
                    end
                    m_flags = {p_data >= 128, 1'b0, p_c, p_data == 0};
                end
            end else if (issue_valid) begin
`ifdef ALU_EXEC_MUL_EN
                if (int'(opcode) == 11) begin
                    m_left = 8;
                    p_data = (int'(src_a) * int'(src_b)) % 256;
                    p_c    = (int'(src_a) * int'(src_b)) > 255;
                    p_dest = int'(dest_addr);
                end else
`endif
                begin
                    model_op(int'(opcode), int'(src_a), int'(src_b), wr, upd, r, fl);
                    if (wr && int'(dest_addr) < 5) begin
                        m_we = 1; m_addr = int'(dest_addr); m_data = r;
                    end
                    if (upd) m_flags = fl;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_write_enable", write_enable, m_we);
            if (m_we) begin
                chk("cyc_write_addr", write_addr, m_addr);
                chk("cyc_write_data", write_data, m_data);
            end
            chk("cyc_flags", flags, m_flags);
            chk("cyc_issue_ready", issue_ready, m_left == 0);
            chk("cyc_busy", busy, m_left > 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic put(input logic [3:0] op, input logic [2:0] d,
                       input logic [7:0] a, input logic [7:0] b);
        issue_valid = 1'b1;
        opcode      = op;
        dest_addr   = d;
        src_a       = a;
        src_b       = b;
    endtask

    // Called at a negedge with an op presented; returns just after the accept edge
    task automatic wait_accept();
        int g = 0;
        while (!issue_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: issue_ready stayed 0 for %0d cycles", g);
        end
        @(posedge clk);
    endtask

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        issue_valid = 1'b0;
        opcode = 4'h0; dest_addr = 3'd0; src_a = 8'h00; src_b = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_write_enable", write_enable, 1'b0);
        chk("rst_write_addr", write_addr, 3'd0);
        chk("rst_write_data", write_data, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);

        // ADD 0xAA + 0x55 -> 0xFF, N only
        put(4'h0, 3'd0, 8'hAA, 8'h55);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("add_we", write_enable, 1'b1);
        chk("add_addr", write_addr, 3'd0);
        chk("add_data", write_data, 8'hFF);
        chk("add_flags", flags, 4'b1000);

        // Back-to-back SUB then INC with valid held
        put(4'h1, 3'd1, 8'h10, 8'h20);
        wait_accept();
        @(negedge clk);
        put(4'h8, 3'd2, 8'hFF, 8'h00);
        chk("sub_we", write_enable, 1'b1);
        chk("sub_addr", write_addr, 3'd1);
        chk("sub_data", write_data, 8'hF0);
        chk("sub_flags", flags, 4'b1010);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("inc_we", write_enable, 1'b1);
        chk("inc_addr", write_addr, 3'd2);
        chk("inc_data", write_data, 8'h00);
        chk("inc_flags", flags, 4'b0011);

        // CMP equal: no write, Z
        put(4'hA, 3'd0, 8'h0F, 8'h0F);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("cmp_we", write_enable, 1'b0);
        chk("cmp_flags", flags, 4'b0001);

        // ADD to dest 5: suppressed write, flags N,V
        put(4'h0, 3'd5, 8'h7F, 8'h01);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("dest5_we", write_enable, 1'b0);
        chk("dest5_flags", flags, 4'b1100);

        // NOP 0xC: flags unchanged
        put(4'hC, 3'd0, 8'h12, 8'h34);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("nop_we", write_enable, 1'b0);
        chk("nop_flags", flags, 4'b1100);

`ifdef ALU_EXEC_MUL_EN
        // MUL 0x0F * 0x11 = 0xFF, 8 busy cycles then write
        put(4'hB, 3'd4, 8'h0F, 8'h11);
        wait_accept();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            chk("mul_busy", busy, 1'b1);
            chk("mul_ready", issue_ready, 1'b0);
        end
        @(negedge clk);
        chk("mul_we", write_enable, 1'b1);
        chk("mul_addr", write_addr, 3'd4);
        chk("mul_data", write_data, 8'hFF);
        chk("mul_flags", flags, 4'b1000);
        // MUL 0x20 * 0x10 = 0x200 -> 0x00, C and Z
        put(4'hB, 3'd0, 8'h20, 8'h10);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mul2_we", write_enable, 1'b1);
        chk("mul2_data", write_data, 8'h00);
        chk("mul2_flags", flags, 4'b0011);
        // Reset during MUL cycle 4 aborts it
        @(negedge clk);
        put(4'hB, 3'd1, 8'h03, 8'h05);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_flags", flags, 4'h0);
        chk("abort_ready", issue_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("abort_no_write", write_enable, 1'b0);
            @(negedge clk);
        end
`else
        // Opcode 0xB is a NOP without the multiplier
        put(4'h1, 3'd3, 8'h00, 8'h01);
        wait_accept();
        @(negedge clk);
        put(4'hB, 3'd0, 8'h03, 8'h05);
        wait_accept();
        @(negedge clk);
        issue_valid = 1'b0;
        chk("opb_we", write_enable, 1'b0);
        chk("opb_flags", flags, 4'b1010);
        chk("opb_busy", busy, 1'b0);
        chk("opb_ready", issue_ready, 1'b1);
`endif

        // Randomized traffic with occasional idle gaps
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                issue_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            put(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                pick_operand(), pick_operand());
            wait_accept();
        end
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
